// File: rtl/spawn_sched_pkg.sv
// Shared types and constants for the spawn scheduler: FSM states, register map, queue entry.
// Entry field widths here set the defaults for the TYPE_W / DELAY_W parameters of the top.
package spawn_sched_pkg;

    localparam int unsigned SpawnTypeW  = 3;
    localparam int unsigned SpawnDelayW = 8;

    localparam logic [1:0] AddrPush   = 2'd0;
    localparam logic [1:0] AddrStatus = 2'd1;
    localparam logic [1:0] AddrCtrl   = 2'd2;
    localparam logic [1:0] AddrMinGap = 2'd3;

    localparam int unsigned StatusEmptyBit = 8;
    localparam int unsigned StatusFullBit  = 9;
    localparam int unsigned StatusOvfBit   = 10;
    localparam int unsigned StatusStateLsb = 12;

    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlFlushBit = 1;
    localparam int unsigned CtrlIrqEnBit = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StOffer = 2'd2,
        StGap   = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [SpawnTypeW-1:0]  kind;
        logic [SpawnDelayW-1:0] delay;
    } spawn_entry_t;

endpackage

// File: rtl/spawn_fifo.sv
// Single-clock FIFO of spawn entries with synchronous flush; push while full is dropped
// unless a pop happens in the same cycle.
module spawn_fifo import spawn_sched_pkg::*; #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  spawn_entry_t    wdata_i,
    output spawn_entry_t    rdata_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    spawn_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Avalon-MM spawn scheduler: queues spawn entries and releases them paced by frame ticks.
// Optional completion interrupt enabled by defining SPAWN_SCHED_IRQ_EN.
module spawn_scheduler import spawn_sched_pkg::*; #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TYPE_W  = SpawnTypeW,
    parameter int unsigned DELAY_W = SpawnDelayW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              frame_tick,
    output logic              spawn_valid,
    output logic [TYPE_W-1:0] spawn_type,
    input  logic              spawn_ready
`ifdef SPAWN_SCHED_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    sched_state_e      state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [TYPE_W-1:0]  type_q, type_d;
    logic [DELAY_W-1:0] min_gap_q, min_gap_d;
    logic               enable_q, enable_d;
    logic               overflow_q, overflow_d;

    logic         wr_en, push, pop, flush, handshake, ctrl_wr;
    spawn_entry_t push_entry, head;
    logic [CntW-1:0] fifo_count;
    logic         fifo_full, fifo_empty;
    logic         unused_wd;

    assign wr_en     = chipselect && !write_n;
    assign push      = wr_en && (address == AddrPush);
    assign ctrl_wr   = wr_en && (address == AddrCtrl);
    assign flush     = ctrl_wr && writedata[CtrlFlushBit];
    assign handshake = (state_q == StOffer) && spawn_ready;
    assign pop       = (state_q == StIdle) && enable_q && !fifo_empty && !flush;
    assign unused_wd = ^writedata[31:16];

    assign push_entry.kind  = writedata[TYPE_W-1:0];
    assign push_entry.delay = writedata[8 +: DELAY_W];

    spawn_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A zero delay goes straight to OFFER; otherwise the tick that brings the counter to 0
    // also moves the FSM on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        type_d = head.kind;
                        if (head.delay == '0) begin
                            state_d = StOffer;
                        end else begin
                            cnt_d   = head.delay;
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0 || (frame_tick && cnt_q == DELAY_W'(1))) begin
                        cnt_d   = '0;
                        state_d = StOffer;
                    end else if (frame_tick) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StOffer: begin
                    if (spawn_ready) begin
                        if (min_gap_q == '0) begin
                            state_d = StIdle;
                        end else begin
                            cnt_d   = min_gap_q;
                            state_d = StGap;
                        end
                    end
                end
                StGap: begin
                    if (cnt_q == '0 || (frame_tick && cnt_q == DELAY_W'(1))) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else if (frame_tick) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        enable_d   = enable_q;
        min_gap_d  = min_gap_q;
        overflow_d = overflow_q;
        if (ctrl_wr) enable_d = writedata[CtrlEnBit];
        if (wr_en && address == AddrMinGap) min_gap_d = writedata[DELAY_W-1:0];
        if (wr_en && address == AddrStatus && writedata[StatusOvfBit]) overflow_d = 1'b0;
        if (push && fifo_full && !pop && !flush) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            type_q     <= '0;
            min_gap_q  <= '0;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            min_gap_q  <= min_gap_d;
            enable_q   <= enable_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SPAWN_SCHED_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        irq_d    = irq_q;
        if (ctrl_wr) irq_en_d = writedata[CtrlIrqEnBit];
        if (ctrl_wr) begin
            irq_d = 1'b0;
        end else if (handshake && fifo_empty && !push && irq_en_q) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic irq_en_q;
    logic unused_hs;
    assign irq_en_q  = 1'b0;
    assign unused_hs = handshake;
`endif

    assign spawn_valid = (state_q == StOffer);
    assign spawn_type  = type_q;

    always_comb begin
        readdata = '0;
        case (address)
            AddrPush: readdata = '0;
            AddrStatus: begin
                readdata[CntW-1:0]               = fifo_count;
                readdata[StatusEmptyBit]         = fifo_empty;
                readdata[StatusFullBit]          = fifo_full;
                readdata[StatusOvfBit]           = overflow_q;
                readdata[StatusStateLsb +: 2]    = state_q;
            end
            AddrCtrl: begin
                readdata[CtrlEnBit]    = enable_q;
                readdata[CtrlIrqEnBit] = irq_en_q;
            end
            AddrMinGap: readdata[DELAY_W-1:0] = min_gap_q;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler; inputs change and outputs are sampled on the falling edge.
// Define SPAWN_SCHED_IRQ_EN to include the interrupt checks.
module tb_spawn_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        frame_tick;
    logic        spawn_valid;
    logic [2:0]  spawn_type;
    logic        spawn_ready;
`ifdef SPAWN_SCHED_IRQ_EN
    logic        irq;
`endif

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    localparam logic [1:0] APush = 2'd0, AStat = 2'd1, ACtrl = 2'd2, AGap = 2'd3;

    always #5 clk = ~clk;

    spawn_scheduler #(
        .DEPTH   (8),
        .TYPE_W  (3),
        .DELAY_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .frame_tick  (frame_tick),
        .spawn_valid (spawn_valid),
        .spawn_type  (spawn_type),
        .spawn_ready (spawn_ready)
`ifdef SPAWN_SCHED_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start on a falling edge; writes end on the next falling edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1;
        #1;
        check_eq(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic accept();
        spawn_ready = 1'b1;
        @(negedge clk);
        spawn_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        frame_tick = 1'b0; spawn_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        expect_reg("rst_status", AStat, 32'h100);
        expect_reg("rst_ctrl", ACtrl, 32'h0);
        expect_reg("rst_gap", AGap, 32'h0);
        expect_reg("rst_push_rd", APush, 32'h0);
        check_eq("rst_valid", {31'd0, spawn_valid}, 32'd0);
        check_eq("rst_type", {29'd0, spawn_type}, 32'd0);

        // Zero-delay latency and hold while not ready
        bus_write(ACtrl, 32'h1);
        bus_write(AGap, 32'h0);
        bus_write(APush, 32'h005);
        expect_reg("lat_status_n1", AStat, 32'h001);
        check_eq("lat_valid_n1", {31'd0, spawn_valid}, 32'd0);
        idle(1);
        expect_reg("lat_status_n2", AStat, 32'h2100);
        for (int i = 0; i < 10; i++) begin
            check_eq("hold_valid", {31'd0, spawn_valid}, 32'd1);
            check_eq("hold_type", {29'd0, spawn_type}, 32'd5);
            idle(1);
        end
        accept();
        check_eq("acc_valid", {31'd0, spawn_valid}, 32'd0);
        expect_reg("acc_status", AStat, 32'h100);

        // Delay 3 and MIN_GAP 2; tick in the pop cycle is ignored
        bus_write(AGap, 32'h2);
        bus_write(APush, 32'h302);
        frame_tick = 1'b1;
        bus_write(APush, 32'h006);
        frame_tick = 1'b0;
        expect_reg("wait_status", AStat, 32'h1001);
        tick();
        tick();
        check_eq("wait_valid_2t", {31'd0, spawn_valid}, 32'd0);
        idle(2);
        expect_reg("wait_status_2t", AStat, 32'h1001);
        tick();
        check_eq("offer2_valid", {31'd0, spawn_valid}, 32'd1);
        check_eq("offer2_type", {29'd0, spawn_type}, 32'd2);
        expect_reg("offer2_status", AStat, 32'h2001);
        accept();
        check_eq("gap_valid", {31'd0, spawn_valid}, 32'd0);
        expect_reg("gap_status", AStat, 32'h3001);
        tick();
        idle(3);
        check_eq("gap_valid_1t", {31'd0, spawn_valid}, 32'd0);
        expect_reg("gap_status_1t", AStat, 32'h3001);
        tick();
        expect_reg("gap_done_status", AStat, 32'h0001);
        idle(1);
        check_eq("offer6_valid", {31'd0, spawn_valid}, 32'd1);
        check_eq("offer6_type", {29'd0, spawn_type}, 32'd6);
        accept();
        tick();
        tick();
        expect_reg("chain_end_status", AStat, 32'h100);

        // Overflow with enable off
        bus_write(AGap, 32'h0);
        bus_write(ACtrl, 32'h0);
        for (int i = 0; i < 9; i++) bus_write(APush, 32'(i));
        expect_reg("ovf_status", AStat, 32'h608);
        bus_write(AStat, 32'h400);
        expect_reg("ovf_clr_status", AStat, 32'h208);

        // Push and pop in the same cycle while full
        bus_write(ACtrl, 32'h1);
        bus_write(APush, 32'h007);
        expect_reg("full_pp_status", AStat, 32'h2208);
        check_eq("full_pp_type", {29'd0, spawn_type}, 32'd0);
        bus_write(ACtrl, 32'h2);
        expect_reg("flush1_status", AStat, 32'h100);
        expect_reg("flush1_ctrl", ACtrl, 32'h0);

        // Flush during OFFER with 4 entries queued
        for (int i = 1; i <= 5; i++) bus_write(APush, 32'(i));
        expect_reg("q5_status", AStat, 32'h005);
        bus_write(ACtrl, 32'h1);
        idle(1);
        check_eq("fl_offer_valid", {31'd0, spawn_valid}, 32'd1);
        check_eq("fl_offer_type", {29'd0, spawn_type}, 32'd1);
        expect_reg("fl_offer_status", AStat, 32'h2004);
        bus_write(ACtrl, 32'h3);
        check_eq("fl_valid", {31'd0, spawn_valid}, 32'd0);
        check_eq("fl_type_kept", {29'd0, spawn_type}, 32'd1);
        expect_reg("fl_status", AStat, 32'h100);
        expect_reg("fl_ctrl", ACtrl, 32'h1);
        idle(2);
        check_eq("fl_valid_later", {31'd0, spawn_valid}, 32'd0);

`ifdef SPAWN_SCHED_IRQ_EN
        bus_write(ACtrl, 32'h5);
        bus_write(APush, 32'h003);
        idle(1);
        check_eq("irq_pre", {31'd0, irq}, 32'd0);
        accept();
        check_eq("irq_set", {31'd0, irq}, 32'd1);
        expect_reg("irq_ctrl", ACtrl, 32'h5);
        bus_write(ACtrl, 32'h5);
        check_eq("irq_clr", {31'd0, irq}, 32'd0);
`else
        bus_write(ACtrl, 32'h5);
        expect_reg("noirq_ctrl", ACtrl, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
